// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions for the bus-layer masters and arbiters.
// Holds the arbiter state encoding, response codes and default widths.
package axi4_lite_pkg;

    localparam int AXI_DEFAULT_ADDR_WIDTH = 32;
    localparam int AXI_DEFAULT_DATA_WIDTH = 32;
    localparam int AXI_DEFAULT_STRB_WIDTH = AXI_DEFAULT_DATA_WIDTH / 8;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam int ARB_PERF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_ACK  = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_t;

    function automatic int arb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant.
// Shared by the write- and read-side arbiters.
module rr_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = arb_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDXW-1:0]    grant_idx,
    output logic               grant_valid
);

    int            idx;
    logic [IDXW-1:0] idx_w;

    // scan last_grant+1 .. last_grant+NUM_REQ and take the first hit
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        idx          = 0;
        idx_w        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(last_grant) + k) % NUM_REQ;
            idx_w = IDXW'(idx);
            if (!grant_valid && req[idx_w]) begin
                grant_valid         = 1'b1;
                grant_idx           = idx_w;
                grant_onehot[idx_w] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// Round-robin write arbiter in front of one axi4_lite_write_master.
// WRITE_ARB_PERF_CNT_EN adds per-requester grant counters (grant_count, perf_clr).
module axi4_lite_write_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = AXI_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DEFAULT_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          arb_busy,
    output logic                          write_start,
    output logic [ADDR_WIDTH-1:0]         write_addr,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [STRB_WIDTH-1:0]         write_strobe,
`ifdef WRITE_ARB_PERF_CNT_EN
    input  logic                          perf_clr,
    output logic [NUM_REQ*16-1:0]         grant_count,
`endif
    input  logic                          write_busy
);

    localparam int IDXW = arb_idx_width(NUM_REQ);

    arb_state_t          state_q;
    logic [IDXW-1:0]     last_grant_q;
    logic [NUM_REQ-1:0]  grant_oh_q;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDXW-1:0]     pick_idx;
    logic                pick_valid;
    logic                grant_fire;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [STRB_WIDTH-1:0] sel_strb;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr (
        .req          (req_valid),
        .last_grant   (last_grant_q),
        .grant_onehot (pick_oh),
        .grant_idx    (pick_idx),
        .grant_valid  (pick_valid)
    );

    // no grant while a foreign transfer runs or while req_done is pulsing
    assign grant_fire = rst_n
                      && (state_q == ARB_IDLE)
                      && pick_valid
                      && !write_busy
                      && !(|req_done);

    assign req_ready = grant_fire ? pick_oh : '0;
    assign arb_busy  = (state_q != ARB_IDLE);

    // one-hot mux of the winning requester's payload slice
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_strb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    // grant / issue / wait-ack / wait-done sequencing with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            grant_oh_q   <= '0;
            write_start  <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            write_strobe <= '0;
            req_done     <= '0;
        end else begin
            write_start <= 1'b0;
            req_done    <= '0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_fire) begin
                        state_q      <= ARB_ISSUE;
                        last_grant_q <= pick_idx;
                        grant_oh_q   <= pick_oh;
                        write_addr   <= sel_addr;
                        write_data   <= sel_data;
                        write_strobe <= sel_strb;
                        write_start  <= 1'b1;
                    end
                end
                ARB_ISSUE: begin
                    state_q <= ARB_WAIT_ACK;
                end
                ARB_WAIT_ACK: begin
                    if (write_busy) begin
                        state_q <= ARB_WAIT_DONE;
                    end
                end
                ARB_WAIT_DONE: begin
                    if (!write_busy) begin
                        state_q  <= ARB_IDLE;
                        req_done <= grant_oh_q;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef WRITE_ARB_PERF_CNT_EN
    logic [15:0] cnt_q [NUM_REQ];

    // saturating per-requester grant counters; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (perf_clr) begin
                    cnt_q[i] <= '0;
                end else if (req_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // flatten counters onto the output bus
    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: doc/axi4_lite_write_arbiter.md
Name: axi4_lite_write_arbiter

Overview:
- Shares one axi4_lite_write_master among NUM_REQ write requesters, e.g. CPU store port, debug port and DMA.
- Arbitrates round-robin and latches the winner's payload.
- Sequences the master's write_start/write_busy interface and returns a per-requester completion pulse.
- Sits between the requesters and the write master in the SoC bus layer.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- STRB_WIDTH, DATA_WIDTH/8, strobe width.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester write request, held until req_ready
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_strb  in  NUM_REQ*STRB_WIDTH  flattened byte strobes
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse; payload is sampled in the same cycle
- req_done  out  NUM_REQ  one-hot, 1-cycle completion pulse to the granted requester
- arb_busy  out  1  high whenever state != IDLE
- write_start  out  1  1-cycle start pulse to the write master
- write_addr  out  ADDR_WIDTH  latched address
- write_data  out  DATA_WIDTH  latched data
- write_strobe  out  STRB_WIDTH  latched strobe
- write_busy  in  1  write master busy

Behaviour:
- Reset (async assert, sync release): state=IDLE; req_ready=0; req_done=0; write_start=0; write_addr/data/strobe=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- FSM states:
  - IDLE: a grant requires |req_valid and write_busy==0. The winner is the first set index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
    - On grant: pulse req_ready[g], latch payload slice g into write_addr/data/strobe, set last_grant=g, go to ISSUE.
    - If write_busy==1 (foreign transfer in flight), no grant is issued.
  - ISSUE: write_start=1 for exactly this cycle. Go to WAIT_ACK.
  - WAIT_ACK: wait for write_busy==1, then go to WAIT_DONE.
    - write_start is never reasserted in this state.
  - WAIT_DONE: wait for write_busy==0, then pulse req_done[g] and go to IDLE.
- Pulse timing: req_done and the next req_ready are never asserted in the same cycle. The earliest next grant is the cycle after req_done.
- Latency: request in IDLE with write_busy=0 gives req_ready in cycle 0 and write_start in cycle 1. req_done is 1 cycle after write_busy falls (registered).
- Payload stability: write_addr/data/strobe hold their values from grant until the next grant. Requesters may change inputs freely after req_ready.
- Requester rules:
  - Dropping req_valid before req_ready withdraws the request.
  - req_valid held high after req_ready counts as a new request.
- Fairness: if all requesters are held high, the grant sequence is 0,1,...,NUM_REQ-1,0,... Any requester is granted within NUM_REQ transfers.
- Reset mid-transfer forces IDLE with outputs at reset values. The in-flight master transfer is abandoned, and the master is reset by the same reset.
- No combinational path from req_* to write_* outputs. All outputs are registered.

Optional Feature:
- Macro: WRITE_ARB_PERF_CNT_EN
- With the macro defined:
  - Adds output grant_count, width NUM_REQ*16, one 16-bit counter per requester. Slice i increments on each req_ready[i].
  - Each counter saturates at 16'hFFFF and is cleared by reset.
  - Adds input perf_clr (1 bit). perf_clr synchronously zeroes all counters and takes priority over an increment in the same cycle.
- Without the macro: ports and logic are absent and the behaviour above is unchanged.

Decomposition:
- Package axi4_lite_pkg (shared with the read/write masters) holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT_ACK, ARB_WAIT_DONE}
  - AXI_RESP_OKAY = 2'b00
  - default width localparams
- Sub-module rr_arbiter: pure combinational round-robin pick from (req vector, last_grant). Outputs grant_onehot, grant_idx, grant_valid. It is reused later by the read-side arbiter.

Test Plan:
- Single request: req_valid=2'b01, addr 32'h0000_1000, data 32'hDEAD_BEEF, strb 4'hF.
  - req_ready[0] pulses in the same cycle; write_start pulses 1 cycle later with those values.
  - Master model raises busy for 4 cycles; req_done[0] pulses 1 cycle after busy falls.
- Simultaneous requests with both held: req0 32'h1000/32'h11111111, req1 32'h2000/32'h22222222.
  - Grant order is 0,1,0,1 over 4 transfers.
  - Exactly one write_start per transfer, with matching payload each time.
- Foreign busy: write_busy forced to 1 in IDLE while req_valid=2'b10.
  - No req_ready and no write_start while busy is high.
  - Grant to requester 1 in the cycle after busy drops.
- Payload isolation: requester changes req_data to 32'hBAD0BAD0 the cycle after req_ready.
  - write_data stays 32'hCAFEBABE for the whole transfer.
- Reset mid-operation: assert rst_n=0 while in WAIT_DONE.
  - All outputs read 0 immediately (async); after release, state is IDLE and req 0 wins first.
- WRITE_ARB_PERF_CNT_EN build: 3 transfers for req0, 1 for req1.
  - grant_count slices read 3 and 1.
  - perf_clr pulse zeroes both.
